dvg_vector_timer: RTL

Vector-drawing responder for the DVG. The instruction state machine latches a vector's scale, deltas and intensity, then pulses `go`. This block steps the X/Y beam position with a per-axis DDA accumulator over a scale-dependent number of clocks and drives the beam intensity while drawing. It returns a one-cycle `stop` when the vector completes. It also performs LABS absolute-position loads and aborts on halt.

---
 rtl/dvg_pkg.sv | 41 ++++
 rtl/dvg_dda_axis.sv | 69 ++++++
 rtl/dvg_vector_timer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dvg_pkg.sv
// Shared DVG definitions: position width, scale limit, opcodes, vector timer state encoding.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package dvg_pkg;

    // Beam position / delta magnitude width, fixed by the display
    localparam int POS_W = 10;

    // Largest meaningful vector scale; larger values draw as this one
    localparam logic [3:0] SCALE_MAX = 4'd9;

    // DVG opcodes (upper nibble of the instruction word)
    localparam logic [3:0] VCTR_DIV_512 = 4'h0;
    localparam logic [3:0] VCTR_DIV_256 = 4'h1;
    localparam logic [3:0] VCTR_DIV_128 = 4'h2;
    localparam logic [3:0] VCTR_DIV_64  = 4'h3;
    localparam logic [3:0] VCTR_DIV_32  = 4'h4;
    localparam logic [3:0] VCTR_DIV_16  = 4'h5;
    localparam logic [3:0] VCTR_DIV_8   = 4'h6;
    localparam logic [3:0] VCTR_DIV_4   = 4'h7;
    localparam logic [3:0] VCTR_DIV_2   = 4'h8;
    localparam logic [3:0] VCTR_DIV_1   = 4'h9;
    localparam logic [3:0] LABS         = 4'hA;
    localparam logic [3:0] HALT         = 4'hB;
    localparam logic [3:0] JSRL         = 4'hC;
    localparam logic [3:0] RTSL         = 4'hD;
    localparam logic [3:0] JMPL         = 4'hE;
    localparam logic [3:0] SVEC         = 4'hF;

    // Vector timer state encoding
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } state_t;

    // Saturate an incoming scale to the largest supported value
    function automatic logic [3:0] clamp_scale(input logic [3:0] s);
        return (s > SCALE_MAX) ? SCALE_MAX : s;
    endfunction

endpackage

// File: rtl/dvg_dda_axis.sv
// One beam axis: DDA accumulator, carry-driven +/-1 position step, absolute load, optional clip.
// Latency: position updates on the edge that sees a load or a step carry.
// Backpressure: none; steps only when the controller asserts i_step. Clip build: VTIMER_CLIP_EN.
module dvg_dda_axis #(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_pos,
    input  logic         i_start,
    input  logic [W-1:0] i_mag,
    input  logic         i_neg,
    input  logic         i_step,
    output logic [W-1:0] o_pos,
    output logic         o_clip
);
    import dvg_pkg::*;

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_acc;
    logic [W-1:0] r_mag;
    logic         r_neg;
    logic [W-1:0] r_pos;

    logic [W:0]   w_sum;
    logic         w_carry;
    logic         w_clip_evt;
    logic [W-1:0] w_next_pos;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_mag};
    assign w_carry = w_sum[W];

`ifdef VTIMER_CLIP_EN
    // A carry that would step past either screen edge holds the position instead
    assign w_clip_evt = w_carry & (r_neg ? (r_pos == '0) : (&r_pos));
    assign w_next_pos = w_clip_evt ? r_pos : (r_neg ? (r_pos - ONE) : (r_pos + ONE));
`else
    // Positions simply wrap around the screen
    assign w_clip_evt = 1'b0;
    assign w_next_pos = r_neg ? (r_pos - ONE) : (r_pos + ONE);
`endif

    assign o_pos  = r_pos;
    assign o_clip = i_step & w_clip_evt;

    // Absolute load, vector start capture, and per-clock DDA stepping
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc <= '0;
            r_mag <= '0;
            r_neg <= 1'b0;
            r_pos <= '0;
        end else if (i_load) begin
            r_pos <= i_load_pos;
        end else if (i_start) begin
            r_acc <= '0;
            r_mag <= i_mag;
            r_neg <= i_neg;
        end else if (i_step) begin
            r_acc <= w_sum[W-1:0];
            if (w_carry) begin
                r_pos <= w_next_pos;
            end
        end
    end

endmodule

// File: rtl/dvg_vector_timer.sv
// DVG vector timer: runs a 2^(scale+1)-clock DDA draw per go, LABS loads, halt aborts, one-cycle stop.
// Latency: go at E0 -> busy for N cycles, last step and stop at E_N; labs lands on its sampling edge.
// Backpressure: go/labs are only sampled while idle; requests during busy are dropped. Clip build: VTIMER_CLIP_EN.
module dvg_vector_timer #(
    parameter int POS_W = dvg_pkg::POS_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_go,
    input  logic             i_labs,
    input  logic             i_halt,
    input  logic [3:0]       i_scale,
    input  logic [POS_W-1:0] i_dx_mag,
    input  logic [POS_W-1:0] i_dy_mag,
    input  logic             i_dx_neg,
    input  logic             i_dy_neg,
    input  logic [3:0]       i_z_in,
    input  logic [POS_W-1:0] i_x_abs,
    input  logic [POS_W-1:0] i_y_abs,
    output logic [POS_W-1:0] o_x,
    output logic [POS_W-1:0] o_y,
    output logic [3:0]       o_z,
    output logic             o_busy,
    output logic             o_stop
);
    import dvg_pkg::*;

    state_t           r_state;
    logic [POS_W-1:0] r_cnt;
    logic [3:0]       r_z;
    logic             r_busy;
    logic             r_stop;

    logic             w_idle;
    logic             w_load;
    logic             w_start;
    logic             w_step;
    logic [3:0]       w_scale;
    logic [POS_W-1:0] w_cnt_init;
    logic             w_clip_x;
    logic             w_clip_y;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_load  = w_idle & i_labs;
    assign w_start = w_idle & i_go & ~i_labs;
    // halt suppresses the step on the edge that aborts the vector
    assign w_step  = (r_state == ST_DRAW) & ~i_halt;
    assign w_scale = clamp_scale(i_scale);
    // N-1 where N = 2^(scale+1): a mask of scale+1 low ones
    assign w_cnt_init = ~({POS_W{1'b1}} << (w_scale + 4'd1));

    dvg_dda_axis #(.W(POS_W)) u_axis_x (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_load_pos (i_x_abs),
        .i_start    (w_start),
        .i_mag      (i_dx_mag),
        .i_neg      (i_dx_neg),
        .i_step     (w_step),
        .o_pos      (o_x),
        .o_clip     (w_clip_x)
    );

    dvg_dda_axis #(.W(POS_W)) u_axis_y (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_load_pos (i_y_abs),
        .i_start    (w_start),
        .i_mag      (i_dy_mag),
        .i_neg      (i_dy_neg),
        .i_step     (w_step),
        .o_pos      (o_y),
        .o_clip     (w_clip_y)
    );

    // IDLE/DRAW control with registered busy, intensity and stop pulse
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_z     <= '0;
            r_busy  <= 1'b0;
            r_stop  <= 1'b0;
        end else begin
            r_stop <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_cnt   <= w_cnt_init;
                        r_z     <= i_z_in;
                        r_busy  <= 1'b1;
                        r_state <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (i_halt) begin
                        r_z     <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_z     <= '0;
                        r_busy  <= 1'b0;
                        r_stop  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        // beam blanks for the rest of the vector once it hits an edge
                        if (w_clip_x | w_clip_y) begin
                            r_z <= '0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_z    = r_z;
    assign o_busy = r_busy;
    assign o_stop = r_stop;

endmodule
